// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop modulo counter: mode encodings and
// the helper that sizes the terminal value MOD-1.
package tff_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Terminal count value as a plain integer; callers truncate it to WIDTH bits,
  // which keeps MOD == 2**WIDTH representable.
  function automatic longint unsigned mod_max(input longint unsigned mod);
    return mod - 64'd1;
  endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single toggle cell: q flips on every edge where t is high; no arithmetic here.
module t_ff_cell (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (!rstn) q_q <= 1'b0;
    else       q_q <= q_q ^ t;
  end

  assign q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from a bank of T flip-flops. The parent decides
// the next count value and converts it into a per-bit toggle vector.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 1 || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_param
    $fatal(1, "tff_mod_counter: illegal WIDTH/MOD");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(mod_max(64'(MOD)));

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] t_vec;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_zero;

  assign at_max  = (cnt_q == MAXV);
  assign at_zero = (cnt_q == '0);

  // Priority: load over count; reset is applied inside the cells and flag regs.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          cnt_d = (mode == MODE_SAT) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          unf_d = 1'b1;
          cnt_d = (mode == MODE_SAT) ? cnt_q : MAXV;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  assign t_vec = cnt_q ^ cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk  (clk),
      .rstn (rstn),
      .t    (t_vec[i]),
      .q    (cnt_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q   = cnt_q;
  assign tc  = en & (up ? at_max : at_zero);
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench: two counters (MOD=10 and MOD=16) share one stimulus stream;
// expected results are queued at drive time and compared after each edge.
module tb_tff_mod_counter;

  logic       clk = 1'b0;
  logic       rstn, en, up, mode, load;
  logic [3:0] load_val;
  logic [3:0] q10, q16;
  logic       tc10, tc16, ovf10, ovf16, unf10, unf16;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .q(q10), .tc(tc10), .ovf(ovf10), .unf(unf10)
  );

  tff_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .q(q16), .tc(tc16), .ovf(ovf16), .unf(unf16)
  );

  typedef struct {
    string tag;
    int    q10, q16;
    bit    o10, u10, o16, u16;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m10 = 0, m16 = 0;
  bit   model_ok = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  // Reference behaviour of one counter for one edge.
  task automatic ref_step(input int mod, input int cur, output int nxt,
                          output bit o, output bit u);
    o = 0; u = 0; nxt = cur;
    if (!rstn) nxt = 0;
    else if (load) nxt = (int'(load_val) > mod - 1) ? mod - 1 : int'(load_val);
    else if (en && up) begin
      if (cur == mod - 1) begin o = 1; nxt = mode ? cur : 0; end
      else nxt = cur + 1;
    end else if (en && !up) begin
      if (cur == 0) begin u = 1; nxt = mode ? cur : mod - 1; end
      else nxt = cur - 1;
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic e, input logic u_i,
                     input logic m, input logic l, input logic [3:0] lv);
    exp_t x, y;
    rstn = r; en = e; up = u_i; mode = m; load = l; load_val = lv;
    #1;
    if (model_ok) begin
      chk({tag, ".tc10"}, int'(tc10), int'(e && (u_i ? m10 == 9 : m10 == 0)));
      chk({tag, ".tc16"}, int'(tc16), int'(e && (u_i ? m16 == 15 : m16 == 0)));
    end
    x.tag = tag;
    ref_step(10, m10, x.q10, x.o10, x.u10);
    ref_step(16, m16, x.q16, x.o16, x.u16);
    exp_q.push_back(x);
    m10 = x.q10; m16 = x.q16;
    if (!r) model_ok = 1'b1;
    @(posedge clk); #1;
    y = exp_q.pop_front();
    if (model_ok) begin
      chk({y.tag, ".q10"},   int'(q10),   y.q10);
      chk({y.tag, ".ovf10"}, int'(ovf10), int'(y.o10));
      chk({y.tag, ".unf10"}, int'(unf10), int'(y.u10));
      chk({y.tag, ".q16"},   int'(q16),   y.q16);
      chk({y.tag, ".ovf16"}, int'(ovf16), int'(y.o16));
      chk({y.tag, ".unf16"}, int'(unf16), int'(y.u16));
    end
  endtask

  initial begin
    rstn = 0; en = 0; up = 0; mode = 0; load = 0; load_val = '0;
    @(negedge clk);
    // 1: reset then wrap-count up
    cyc("rst0", 0, 1, 1, 0, 0, 4'd0);
    cyc("rst1", 0, 1, 1, 0, 0, 4'd0);
    for (int i = 0; i < 12; i++) cyc("up_wrap", 1, 1, 1, 0, 0, 4'd0);
    // 2: clamped load, then saturate up
    cyc("ld_clamp", 1, 0, 1, 1, 1, 4'd13);
    for (int i = 0; i < 3; i++) cyc("up_sat", 1, 1, 1, 1, 0, 4'd0);
    // 3: down wrap through zero
    cyc("ld2", 1, 0, 0, 0, 1, 4'd2);
    for (int i = 0; i < 4; i++) cyc("dn_wrap", 1, 1, 0, 0, 0, 4'd0);
    cyc("dn_sat_ld", 1, 0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 2; i++) cyc("dn_sat", 1, 1, 0, 1, 0, 4'd0);
    // 4: full-range modulus limits
    cyc("ld15a", 1, 0, 1, 0, 1, 4'd15);
    cyc("wrap15", 1, 1, 1, 0, 0, 4'd0);
    cyc("ld15b", 1, 0, 1, 1, 1, 4'd15);
    cyc("sat15", 1, 1, 1, 1, 0, 4'd0);
    cyc("idle", 1, 0, 1, 1, 0, 4'd0);
    // 5: simultaneous events
    cyc("ld5a", 1, 0, 1, 0, 1, 4'd5);
    cyc("ld_beats_en", 1, 1, 1, 0, 1, 4'd7);
    cyc("ld9", 1, 0, 1, 0, 1, 4'd9);
    cyc("ld_over_ovf", 1, 1, 1, 0, 1, 4'd5);
    cyc("rst_beats_ld", 0, 1, 1, 0, 1, 4'd7);
    // 6: reset on the wrap edge clears any pending pulse
    cyc("ld9b", 1, 0, 1, 0, 1, 4'd9);
    cyc("rst_wrap", 0, 1, 1, 0, 0, 4'd0);
    cyc("post_rst", 1, 0, 1, 0, 0, 4'd0);
    cyc("post_rst2", 1, 1, 1, 0, 0, 4'd0);
    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
